// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall console: seven-segment glyphs and debouncer states.
package syscall_pkg;

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    PRESSED
  } db_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp off in every entry, b and d lowercase
  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces the continue button; raises a one-cycle pressEvent per accepted press.
module button_debouncer
  import syscall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pressEvent
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  db_state_t     r_state;
  db_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Synchronizer resets high so a button held through reset reads as still pressed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_RELEASE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    pressEvent = 1'b0;
    unique case (r_state)
      WAIT_RELEASE: begin
        if (!r_sync2) begin
          if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) w_next = IDLE;
          else w_cnt_next = r_cnt + CW'(1);
        end
      end
      IDLE: begin
        if (r_sync2) begin
          if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) w_next = PRESSED;
          else w_cnt_next = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        pressEvent = 1'b1;
        w_next     = WAIT_RELEASE;
      end
      default: w_next = WAIT_RELEASE;
    endcase
  end

endmodule

// File: rtl/syscall_console.sv
// Board-side syscall console: hex print display on a scanned seven-segment array and debounced continue pulse.
module syscall_console
  import syscall_pkg::*;
#(
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned SCAN_PERIOD     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       syscallOutput,
  input  logic              printStrobe,
  input  logic              halted,
  input  logic              continueButton,
  output logic              continuePulse,
  output logic [DIGITS-1:0] anodes,
  output logic [7:0]        segments,
  output logic [15:0]       printCount
);

  localparam int unsigned SW = $clog2(SCAN_PERIOD);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [31:0]       r_value;
  logic [15:0]       r_count;
  logic [SW-1:0]     r_scan;
  logic [DW-1:0]     r_digit;
  logic [DIGITS-1:0] r_anodes;
  logic [7:0]        r_segments;
  logic              r_pulse;
  logic              w_press;
  logic [3:0]        w_nibble;
  logic              w_dp_on;
  logic [DIGITS-1:0] w_onehot;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .button    (continueButton),
    .pressEvent(w_press)
  );

  always_comb begin
    w_nibble = 4'(r_value >> {r_digit, 2'b00});
    w_dp_on  = halted && (r_digit == '0);
    w_onehot = DIGITS'(1) << r_digit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_count <= '0;
    end else if (printStrobe) begin
      r_value <= syscallOutput;
      r_count <= r_count + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scan  <= '0;
      r_digit <= '0;
    end else if (r_scan == SW'(SCAN_PERIOD - 1)) begin
      r_scan  <= '0;
      r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + DW'(1);
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  // Outputs are registered from the current index so anodes and segments change together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_anodes   <= '1;
      r_segments <= SEG_BLANK;
      r_pulse    <= 1'b0;
    end else begin
      r_anodes   <= ~w_onehot;
      r_segments <= hex_glyph(w_nibble) & {~w_dp_on, 7'h7F};
      r_pulse    <= w_press & halted;
    end
  end

  assign anodes        = r_anodes;
  assign segments      = r_segments;
  assign printCount    = r_count;
  assign continuePulse = r_pulse;

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console with SCAN_PERIOD=4 and DEBOUNCE_CYCLES=8.
module tb_syscall_console;

  localparam int unsigned SP = 4;
  localparam int unsigned DG = 8;
  localparam int unsigned DB = 8;
  localparam int unsigned PRESS_LAT = 2 + DB + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] syscallOutput = '0;
  logic        printStrobe = 1'b0;
  logic        halted = 1'b0;
  logic        continueButton = 1'b0;
  logic        continuePulse;
  logic [7:0]  anodes;
  logic [7:0]  segments;
  logic [15:0] printCount;

  int n_tests = 0;
  int n_fail  = 0;

  syscall_console #(
    .DIGITS(DG),
    .SCAN_PERIOD(SP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .syscallOutput (syscallOutput),
    .printStrobe   (printStrobe),
    .halted        (halted),
    .continueButton(continueButton),
    .continuePulse (continuePulse),
    .anodes        (anodes),
    .segments      (segments),
    .printCount    (printCount)
  );

  always #5 clock = ~clock;

  // Segment patterns a..g (active low), bit 7 (dp) excluded
  function automatic logic [6:0] glyph7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Display reference: slot = (edges since reset / SP) mod DG, value = last strobed word
  int unsigned m_edges = 0;
  logic [31:0] m_value = '0;
  logic [15:0] m_count = '0;
  logic [7:0]  exp_an  = 8'hFF;
  logic [7:0]  exp_seg = 8'hFF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_edges <= 0;
      m_value <= '0;
      m_count <= '0;
      exp_an  <= 8'hFF;
      exp_seg <= 8'hFF;
    end else begin
      exp_an  <= ~(8'h01 << ((m_edges / SP) % DG));
      exp_seg <= {~((((m_edges / SP) % DG) == 0) && halted),
                  glyph7(4'(m_value >> (4 * ((m_edges / SP) % DG))))};
      m_edges <= m_edges + 1;
      if (printStrobe) begin
        m_value <= syscallOutput;
        m_count <= m_count + 16'd1;
      end
    end
  end

  int unsigned g_edge = 0;
  int unsigned p_cnt  = 0;
  int unsigned p_time = 0;

  always @(posedge clock) g_edge <= g_edge + 1;

  always @(negedge clock) begin
    if (continuePulse === 1'b1) begin
      p_cnt  <= p_cnt + 1;
      p_time <= g_edge;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_tests += 4;
    if (anodes !== 8'hFF) begin n_fail++; $display("FAIL reset_anodes: got %h expected ff", anodes); end
    if (segments !== 8'hFF) begin n_fail++; $display("FAIL reset_segments: got %h expected ff", segments); end
    if (printCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", printCount); end
    if (continuePulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", continuePulse); end
    reset = 1'b0;
    tick(1);
    n_tests += 2;
    if (anodes !== 8'hFE) begin n_fail++; $display("FAIL first_anodes: got %h expected fe", anodes); end
    if (segments !== 8'hC0) begin n_fail++; $display("FAIL first_segments: got %h expected c0", segments); end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 40; i++) begin
      tick(1);
      n_tests += 4;
      if (anodes !== exp_an) begin n_fail++; $display("FAIL scan_anodes: got %h expected %h", anodes, exp_an); end
      if (segments !== 8'hC0) begin n_fail++; $display("FAIL scan_segments: got %h expected c0", segments); end
      if (printCount !== 16'd0) begin n_fail++; $display("FAIL scan_count: got %0d expected 0", printCount); end
      if (continuePulse !== 1'b0) begin n_fail++; $display("FAIL scan_pulse: got %b expected 0", continuePulse); end
    end
  endtask

  task automatic check_display(input int unsigned cycles);
    for (int i = 0; i < int'(cycles); i++) begin
      tick(1);
      n_tests += 3;
      if (anodes !== exp_an) begin n_fail++; $display("FAIL disp_anodes: got %h expected %h", anodes, exp_an); end
      if (segments !== exp_seg) begin n_fail++; $display("FAIL disp_segments: got %h expected %h", segments, exp_seg); end
      if (printCount !== m_count) begin n_fail++; $display("FAIL disp_count: got %0d expected %0d", printCount, m_count); end
    end
  endtask

  task automatic test_print();
    halted = 1'b0;
    syscallOutput = 32'h0000_0064;
    printStrobe = 1'b1;
    tick(1);
    printStrobe = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      n_tests++;
      if (anodes == 8'hFE && segments !== 8'h99) begin n_fail++; $display("FAIL print_digit0: got %h expected 99", segments); end
      else if (anodes == 8'hFD && segments !== 8'h82) begin n_fail++; $display("FAIL print_digit1: got %h expected 82", segments); end
      else if (anodes != 8'hFE && anodes != 8'hFD && segments !== 8'hC0) begin n_fail++; $display("FAIL print_upper: got %h expected c0", segments); end
    end
    n_tests++;
    if (printCount !== 16'd1) begin n_fail++; $display("FAIL print_count: got %0d expected 1", printCount); end
    for (int k = 0; k < 4; k++) begin
      halted = 1'($urandom_range(0, 1));
      syscallOutput = $urandom;
      printStrobe = 1'b1;
      tick(1);
      printStrobe = 1'b0;
      check_display(32 + $urandom_range(0, 5));
    end
    halted = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    int unsigned n;
    c0 = m_count;
    n = $urandom_range(2, 4);
    for (int i = 0; i < int'(n); i++) begin
      syscallOutput = $urandom;
      printStrobe = 1'b1;
      tick(1);
    end
    printStrobe = 1'b0;
    check_display(33);
    n_tests++;
    if (printCount !== c0 + 16'(n)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", printCount, c0 + 16'(n)); end
  endtask

  task automatic test_clean_press();
    int unsigned t0, p0;
    halted = 1'b1;
    p0 = p_cnt;
    continueButton = 1'b1;
    t0 = g_edge;
    for (int i = 0; i < 20 + int'($urandom_range(0, 10)); i++) begin
      tick(1);
      n_tests++;
      if (segments !== exp_seg) begin n_fail++; $display("FAIL press_segments: got %h expected %h", segments, exp_seg); end
      if (anodes == 8'hFE) begin
        n_tests++;
        if (segments[7] !== 1'b0) begin n_fail++; $display("FAIL press_dp: got %b expected 0", segments[7]); end
      end
    end
    n_tests += 2;
    if (p_cnt !== p0 + 1) begin n_fail++; $display("FAIL press_count: got %0d expected %0d", p_cnt, p0 + 1); end
    if (p_time !== t0 + PRESS_LAT) begin n_fail++; $display("FAIL press_latency: got %0d expected %0d", p_time - t0, PRESS_LAT); end
    continueButton = 1'b0;
    tick(14);
  endtask

  task automatic test_bounce();
    int unsigned per, t_last, p0;
    halted = 1'b1;
    p0 = p_cnt;
    per = $urandom_range(1, 5);
    for (int i = 0; i < 10; i++) begin
      continueButton = (i % 2 == 0);
      tick(per);
    end
    n_tests++;
    if (p_cnt !== p0) begin n_fail++; $display("FAIL bounce_early: got %0d expected %0d", p_cnt, p0); end
    continueButton = 1'b1;
    t_last = g_edge;
    tick(25);
    n_tests += 2;
    if (p_cnt !== p0 + 1) begin n_fail++; $display("FAIL bounce_count: got %0d expected %0d", p_cnt, p0 + 1); end
    if (p_time !== t_last + PRESS_LAT) begin n_fail++; $display("FAIL bounce_latency: got %0d expected %0d", p_time - t_last, PRESS_LAT); end
    continueButton = 1'b0;
    tick(14);
  endtask

  task automatic test_not_halted();
    int unsigned t0, p0;
    p0 = p_cnt;
    halted = 1'b0;
    continueButton = 1'b1;
    tick(20);
    n_tests++;
    if (p_cnt !== p0) begin n_fail++; $display("FAIL nothalt_discard: got %0d expected %0d", p_cnt, p0); end
    halted = 1'b1;
    tick(20);
    n_tests++;
    if (p_cnt !== p0) begin n_fail++; $display("FAIL nothalt_noqueue: got %0d expected %0d", p_cnt, p0); end
    continueButton = 1'b0;
    tick(14);
    continueButton = 1'b1;
    t0 = g_edge;
    tick(20);
    n_tests += 2;
    if (p_cnt !== p0 + 1) begin n_fail++; $display("FAIL nothalt_repress: got %0d expected %0d", p_cnt, p0 + 1); end
    if (p_time !== t0 + PRESS_LAT) begin n_fail++; $display("FAIL nothalt_latency: got %0d expected %0d", p_time - t0, PRESS_LAT); end
    continueButton = 1'b0;
    tick(14);
  endtask

  task automatic test_simultaneous();
    int unsigned t0, p0;
    logic [15:0] c0;
    halted = 1'b1;
    p0 = p_cnt;
    continueButton = 1'b1;
    t0 = g_edge;
    tick(PRESS_LAT - 1);
    c0 = m_count;
    syscallOutput = $urandom;
    printStrobe = 1'b1;
    tick(1);
    printStrobe = 1'b0;
    tick(10);
    n_tests += 3;
    if (p_cnt !== p0 + 1) begin n_fail++; $display("FAIL simul_pulse: got %0d expected %0d", p_cnt, p0 + 1); end
    if (p_time !== t0 + PRESS_LAT) begin n_fail++; $display("FAIL simul_latency: got %0d expected %0d", p_time - t0, PRESS_LAT); end
    if (printCount !== c0 + 16'd1) begin n_fail++; $display("FAIL simul_count: got %0d expected %0d", printCount, c0 + 16'd1); end
    check_display(32);
    continueButton = 1'b0;
    tick(14);
  endtask

  task automatic test_reset_mid();
    int unsigned t0, p0;
    halted = 1'b1;
    p0 = p_cnt;
    continueButton = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(2);
    n_tests += 3;
    if (continuePulse !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b expected 0", continuePulse); end
    if (printCount !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", printCount); end
    if (anodes !== 8'hFF) begin n_fail++; $display("FAIL rstmid_anodes: got %h expected ff", anodes); end
    reset = 1'b0;
    tick(20);
    n_tests++;
    if (p_cnt !== p0) begin n_fail++; $display("FAIL rstmid_held: got %0d expected %0d", p_cnt, p0); end
    continueButton = 1'b0;
    tick(12);
    continueButton = 1'b1;
    t0 = g_edge;
    tick(20);
    n_tests += 2;
    if (p_cnt !== p0 + 1) begin n_fail++; $display("FAIL rstmid_repress: got %0d expected %0d", p_cnt, p0 + 1); end
    if (p_time !== t0 + PRESS_LAT) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected %0d", p_time - t0, PRESS_LAT); end
    continueButton = 1'b0;
    tick(14);

    p0 = p_cnt;
    continueButton = 1'b1;
    repeat (PRESS_LAT) @(posedge clock);
    #2;
    n_tests++;
    if (continuePulse !== 1'b1) begin n_fail++; $display("FAIL rstpulse_before: got %b expected 1", continuePulse); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (continuePulse !== 1'b0) begin n_fail++; $display("FAIL rstpulse_drop: got %b expected 0", continuePulse); end
    tick(2);
    reset = 1'b0;
    tick(20);
    n_tests++;
    if (p_cnt !== p0) begin n_fail++; $display("FAIL rstpulse_none: got %0d expected %0d", p_cnt, p0); end
    continueButton = 1'b0;
    tick(14);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_print();
    test_back_to_back();
    test_clean_press();
    test_bounce();
    test_not_halted();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
